// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for param_fifo
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit params_ok(input int width, input int depth, input int fwft,
                                     input int af_thresh, input int ae_thresh);
        return (width >= 1) && (depth >= 2) &&
               (fwft == FIFO_STD || fwft == FIFO_FWFT) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - storage array, synchronous write, asynchronous read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised synchronous FIFO, any depth, std or FWFT read
module param_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [clog2(DEPTH+1)-1:0] count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);

    if (!params_ok(WIDTH, DEPTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_param_check
        $error("param_fifo: parameter out of range");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] data_q;
    logic             rd_ok;
    logic             wr_ok;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // A write on full is only legal when a read frees a slot in the same cycle.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok && !flush),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_q    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
                data_q <= rd_data;
            end
            count     <= count + CW'(wr_ok) - CW'(rd_ok);
            // A fresh error wins over a simultaneous clear.
            overflow  <= (overflow && !clr_err) || (wr && !wr_ok);
            underflow <= (underflow && !clr_err) || (rd && !rd_ok);
        end
    end

    assign data_out = (FWFT == FIFO_FWFT) ? rd_data : data_q;

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - directed self-checking bench for param_fifo
module tb_param_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       wr = 1'b0, rd = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    logic [7:0] f_data_in = '0;
    logic       f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [2:0] f_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    param_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .wr(wr), .rd(rd),
        .flush(flush), .clr_err(clr_err), .data_out(data_out), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    param_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(reset), .data_in(f_data_in), .wr(f_wr), .rd(f_rd),
        .flush(1'b0), .clr_err(1'b0), .data_out(f_data_out), .full(f_full),
        .empty(f_empty), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr = 1'b1; data_in = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    logic [7:0] fill_vals [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    logic [7:0] after_vals [5] = '{8'h12, 8'h13, 8'h14, 8'h15, 8'hA0};

    initial begin
        // Reset state
        tick();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_af", 32'(almost_full), 0);
        check("rst_dout", 32'(data_out), 0);
        check("rst_flags", {30'd0, overflow, underflow}, 0);
        reset = 1'b1;
        tick();

        // 1: fill to full, then overflow
        for (int i = 0; i < 5; i++) begin
            push(fill_vals[i]);
            check("fill_count", 32'(count), i + 1);
            check("fill_af", 32'(almost_full), (i + 1 >= 3) ? 1 : 0);
            check("fill_full", 32'(full), (i + 1 == 5) ? 1 : 0);
        end
        push(8'h16);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(count), 5);

        // 2: drain, underflow, clear
        for (int i = 0; i < 5; i++) begin
            pop();
            check("drain_data", 32'(data_out), 32'(fill_vals[i]));
        end
        check("drain_empty", 32'(empty), 1);
        pop();
        check("udf_flag", 32'(underflow), 1);
        check("udf_dout_hold", 32'(data_out), 32'h15);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_flags", {30'd0, overflow, underflow}, 0);

        // 3: pointer wrap across non-power-of-two depth
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < 3; j++) push(8'(it * 3 + j));
            check("wrap_peak", 32'(count), 3);
            for (int j = 0; j < 3; j++) begin
                pop();
                check("wrap_data", 32'(data_out), 32'(it * 3 + j));
            end
        end
        check("wrap_empty", 32'(empty), 1);

        // 4: simultaneous rd/wr on full, then on empty
        for (int i = 0; i < 5; i++) push(fill_vals[i]);
        rd = 1'b1; wr = 1'b1; data_in = 8'hA0;
        tick();
        rd = 1'b0; wr = 1'b0;
        check("rw_full_dout", 32'(data_out), 32'h11);
        check("rw_full_count", 32'(count), 5);
        check("rw_full_ovf", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) begin
            pop();
            check("rw_full_drain", 32'(data_out), 32'(after_vals[i]));
        end
        rd = 1'b1; wr = 1'b1; data_in = 8'h33;
        tick();
        rd = 1'b0; wr = 1'b0;
        check("rw_empty_count", 32'(count), 1);
        check("rw_empty_udf", 32'(underflow), 1);
        check("rw_empty_dout", 32'(data_out), 32'hA0);
        pop();
        check("rw_empty_read", 32'(data_out), 32'h33);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // 5a: asynchronous reset between edges
        pop();
        check("pre_rst_udf", 32'(underflow), 1);
        push(8'h01); push(8'h02); push(8'h03);
        check("pre_rst_count", 32'(count), 3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_flags", {30'd0, overflow, underflow}, 0);
        check("arst_dout", 32'(data_out), 0);
        reset = 1'b1;
        tick();

        // 5b: flush overrides rd/wr, leaves flags alone
        pop();
        for (int i = 0; i < 4; i++) push(8'h51 + 8'(i));
        check("pre_flush_count", 32'(count), 4);
        flush = 1'b1; rd = 1'b1; wr = 1'b1; data_in = 8'h99;
        tick();
        flush = 1'b0; rd = 1'b0; wr = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_empty", 32'(empty), 1);
        check("flush_flags", {30'd0, overflow, underflow}, 32'b01);
        check("flush_dout", 32'(data_out), 0);
        push(8'h77);
        pop();
        check("post_flush_read", 32'(data_out), 32'h77);

        // 6: first-word-fall-through
        f_wr = 1'b1; f_data_in = 8'h42;
        tick();
        f_wr = 1'b0;
        check("fwft_not_empty", 32'(f_empty), 0);
        check("fwft_head", 32'(f_data_out), 32'h42);
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        check("fwft_empty", 32'(f_empty), 1);
        f_wr = 1'b1; f_data_in = 8'h43;
        tick();
        f_data_in = 8'h44;
        check("fwft_head2", 32'(f_data_out), 32'h43);
        tick();
        f_wr = 1'b0;
        check("fwft_head_hold", 32'(f_data_out), 32'h43);
        check("fwft_count", 32'(f_count), 2);
        f_rd = 1'b1;
        tick();
        f_rd = 1'b0;
        check("fwft_next", 32'(f_data_out), 32'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO; next-generation replacement for the team's fixed power-of-two queue. Adds:
- arbitrary (non-power-of-two) depth
- selectable standard or first-word-fall-through (FWFT) read mode
- fill count, almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush

Sits between producer/consumer blocks on a single clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, any integer)
FWFT, 0, 0 = registered read data updated after accepted rd; 1 = head word visible on data_out while not empty
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  WIDTH  write data
wr  input  1  write request
rd  input  1  read request
flush  input  1  synchronous clear of contents
clr_err  input  1  clears sticky error flags
data_out  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  CW  entries held, CW = clog2(DEPTH+1)
overflow  output  1  sticky: a write was refused
underflow  output  1  sticky: a read was refused

Behaviour:
- Reset (reset=0): immediate, no clock edge needed.
  - wr_ptr, rd_ptr, count, data_out, overflow, underflow cleared to 0.
  - empty=1, full=0; almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- Read accept: rd_ok = rd && !empty.
- Write accept: wr_ok = wr && (!full || rd_ok). Write on full proceeds only with a simultaneous accepted read.
- Simultaneous read and write:
  - On empty: write accepted, read refused.
  - Otherwise: both accepted, count unchanged.
- count: next = count + wr_ok - rd_ok. Width CW, never exceeds DEPTH.
- Pointers: range 0..DEPTH-1, increment on accept, wrap explicitly from DEPTH-1 to 0. No power-of-two assumption.
- FWFT=0:
  - data_out is registered and loads mem[rd_ptr] on the edge where rd_ok=1 (latency 1).
  - Holds its value otherwise, including on refused reads.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally whenever !empty; undefined when empty.
  - A word written on edge N is visible after edge N (count>=1).
  - rd_ok pops the word.
- Flush (flush=1 at an edge):
  - Pointers and count go to 0; overrides rd/wr that cycle (no accepts, no error set).
  - data_out and error flags unchanged.
- Errors:
  - overflow set when wr && !wr_ok; underflow set when rd && !rd_ok (includes rd on empty with wr).
  - Both are sticky until clr_err or reset.
  - clr_err and a new error in the same cycle: flag stays set.
- Status outputs are combinational decodes of count.
- Memory: one write port, one asynchronous read port; read and write to different addresses in the same cycle.

Decomposition:
- Package fifo_pkg:
  - clog2 constant function
  - FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1)
  - parameter-range checks as elaboration-time assertions
- Sub-module fifo_ram (WIDTH, DEPTH): storage array with synchronous write and asynchronous read. param_fifo keeps pointers, count, flags, and the output register.

Test Plan:
1. WIDTH=8, DEPTH=5, FWFT=0; write 0x11..0x15 -> almost_full=1 at count=3, full=1 at count=5; 6th write 0x16 -> overflow=1, count=5, contents unchanged.
2. Continue with 5 reads -> data_out 0x11,0x12,0x13,0x14,0x15 one cycle after each rd; empty=1; extra rd -> underflow=1, data_out holds 0x15; clr_err -> underflow=0.
3. Wrap: 4 iterations of (write 3 values, read 3) -> 12 words out in order 0x00..0x0B; pointers wrap at 5; count peaks at 3.
4. Full with rd&wr data_in=0xA0 -> data_out=0x11, count=5, overflow=0; empty with rd&wr data_in=0x33 -> count=1, underflow=1, next read returns 0x33.
5. Async reset mid-burst with count=3: drive reset=0 between edges -> count=0, empty=1, flags=0 before the next edge. Separately, flush with count=4 and rd=wr=1 -> count=0, no flag change.
6. FWFT=1: write 0x42 -> after that edge empty=0, data_out=0x42 with no rd; rd -> empty=1; next write 0x43 is visible on data_out after the write edge.
